bit_reducer_stream: RTL
=======================

# bit_reducer_stream

Streaming, packet-oriented successor to the combinational bit reducer. Accepts a stream of INPUT_COUNT-bit words over a valid/ready handshake and treats all beats of a packet as one long bit sequence. It reduces that sequence with a true chained Boolean operation, so each step is applied to the previous partial result. It emits one registered result bit per packet. It sits between a word producer (parity or condition checkers, packet datapaths) and any consumer of a per-packet flag.

## Interface
- OPERATION, "", one of "AND", "NAND", "OR", "NOR", "XOR", "XNOR"; any other value generates no logic.
- INPUT_COUNT, 0, bits per input beat; must be ≥ 1.
- BEAT_COUNT_WIDTH, 8, width of the beat counter; used only with the macro.

- clock  in  1  sole clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- input_valid  in  1  beat present.
- input_ready  out  1  beat accepted when both valid and ready are high.
- input_last  in  1  beat is the final beat of a packet.
- bits_in  in  INPUT_COUNT  beat data; bit 0 is reduced first.
- output_valid  out  1  result held.
- output_ready  in  1  result consumed when both valid and ready are high.
- bit_out  out  1  packet reduction result.
- output_beats  out  BEAT_COUNT_WIDTH  beats in the packet; present only with the macro.

## Operation
- Bit order within a packet is beat 0 bit 0, beat 0 bit 1, and so on up to the last beat's bit INPUT_COUNT-1.
- Result is ((s0 op s1) op s2) op …, with the inversion applied at every step for NAND, NOR and XNOR. It is not the Verilog reduction-operator form.
- A single-bit packet yields s0 unchanged.
- States:
  - IDLE: no partial result.
    - A beat without last goes to ACCUM; the partial becomes the chain of its bits seeded from bit 0.
    - A beat with last goes to DONE.
  - ACCUM: partial result held.
    - A beat continues the chain with the partial as seed for its bit 0: partial op bits_in[0] op ….
    - With last, go to DONE; otherwise stay in ACCUM.
  - DONE: bit_out and output_valid held stable until the handshake.
    - On output_ready with no accepted input beat, go to IDLE.
    - On output_ready with an accepted input beat, the new packet starts: go to ACCUM, or stay in DONE if that beat has last.
- input_ready = (state != DONE) | output_ready.
  - input_ready may depend combinationally on output_ready.
  - There is no combinational path from input_valid to output_valid or bit_out.
- Data and last are ignored when input_valid is low.

## Timing
- Reset values: state IDLE, output_valid 0, bit_out 0, partial 0, output_beats 0.
- clear overrides any handshake in the same cycle.
- clear mid-packet discards the partial result and any held result.
- Latency: output_valid rises the cycle after the last beat is accepted.
- Throughput is one beat per cycle. Back-to-back single-beat packets sustain one result per cycle while output_ready stays high.
- While output_valid is high and output_ready is low, input_ready is 0. No beat is lost or overwritten.

## Configuration
- BIT_REDUCER_STREAM_COUNT_EN
  - Defined: output_beats port exists. It counts the beats accepted in the packet and saturates at 2^BEAT_COUNT_WIDTH−1. It is registered alongside bit_out and held while output_valid is high.
  - Undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package holds:
  - operation encoding constants, with a function mapping the OPERATION string to the encoding;
  - the state encoding (IDLE/ACCUM/DONE).
- Sub-module bit_reducer_step: combinational. Inputs are seed, seed_valid, bits and operation. Output is the chained result.
  - With seed_valid, the chain is seed op b0 op b1 ….
  - Without seed_valid, the chain is b0 op b1 ….
- The top level holds the FSM, the partial/result registers and the counter.

## Test plan
- XNOR, INPUT_COUNT=3, single beat 3'b000 with last -> bit_out=0, where ~^ would give 1. output_valid is high the next cycle.
- XOR, INPUT_COUNT=4, beats 4'b0001, 4'b0011, 4'b0100 (last on the third) -> bit_out=0. output_beats=3 with the macro defined.
- NAND, INPUT_COUNT=2, beats 2'b11 then 2'b11 (last) -> chain 1,1,1,1 gives 0,1,0, so bit_out=0.
- output_ready held low for 5 cycles after a result -> input_ready=0 throughout, and bit_out is stable. Raising output_ready alongside a valid single-beat packet gives a new result the next cycle with no bubble.
- OR, random packets with random valid/ready stalls -> every result matches a scoreboard chained model, and no packet is dropped or duplicated.
- clear asserted during ACCUM and during DONE -> next cycle state is IDLE and output_valid=0. The following packet's result is unaffected by the discarded data.

Source files
------------

// File: rtl/bit_reducer_stream_pkg.sv
// bit_reducer_stream_pkg
//
// Shared definitions for the streaming bit reducer:
//   - op_e     : encoding of the chained Boolean operation
//   - state_e  : packet FSM states (IDLE / ACCUM / DONE)
//   - op_from_name : maps the OPERATION parameter string to op_e
//                    (unknown names map to OP_NONE, which yields no logic)
//   - op_step  : one link of the chain, a op b, with the inversion applied
//                at this step for the inverting operations
package bit_reducer_stream_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NONE = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic op_e op_from_name(input string name);
        op_e op;
        op = OP_NONE;
        if (name == "AND")  op = OP_AND;
        if (name == "NAND") op = OP_NAND;
        if (name == "OR")   op = OP_OR;
        if (name == "NOR")  op = OP_NOR;
        if (name == "XOR")  op = OP_XOR;
        if (name == "XNOR") op = OP_XNOR;
        return op;
    endfunction

    function automatic logic op_step(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_NAND: r = ~(a & b);
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bit_reducer_stream_step.sv
// bit_reducer_step
//
// Combinational chained reduction of one beat.
// Ports:
//   seed        in   partial result carried from earlier beats
//   seed_valid  in   1: chain is seed op b0 op b1 ...; 0: chain is b0 op b1 ...
//   bits        in   beat data, bit 0 reduced first
//   operation   in   op_e encoding
//   result      out  chained result
module bit_reducer_step
    import bit_reducer_stream_pkg::*;
#(
    parameter int INPUT_COUNT = 1
) (
    input  logic                   seed,
    input  logic                   seed_valid,
    input  logic [INPUT_COUNT-1:0] bits,
    input  logic [2:0]             operation,
    output logic                   result
);

    op_e  op;
    logic acc;

    // Walk the beat bit by bit so every step sees the previous partial
    // result, rather than a flat reduction across the whole word.
    always_comb begin
        op  = op_e'(operation);
        acc = seed_valid ? op_step(op, seed, bits[0]) : bits[0];
        for (int i = 1; i < INPUT_COUNT; i++) begin
            acc = op_step(op, acc, bits[i]);
        end
        // An unrecognised operation produces a constant rather than a
        // pass-through of bit 0.
        if (op == OP_NONE) begin
            acc = 1'b0;
        end
        result = acc;
    end

endmodule

// File: rtl/bit_reducer_stream.sv
// bit_reducer_stream
//
// Packet-oriented streaming bit reducer. All beats of a packet form one bit
// sequence (beat 0 bit 0 first) reduced with a chained Boolean operation;
// one registered result bit is emitted per packet.
//
// Optional feature macro: BIT_REDUCER_STREAM_COUNT_EN
//   defined   -> output_beats reports the saturating beat count per packet
//   undefined -> no counter, no output_beats port
//
// Ports:
//   clock         in   rising-edge clock
//   clear         in   synchronous active-high reset
//   input_valid   in   beat present
//   input_ready   out  beat accepted when valid & ready
//   input_last    in   final beat of the packet
//   bits_in       in   beat data (INPUT_COUNT bits)
//   output_valid  out  result held
//   output_ready  in   result consumed when valid & ready
//   bit_out       out  packet reduction result
//   output_beats  out  beats in the packet (macro only)
module bit_reducer_stream
    import bit_reducer_stream_pkg::*;
#(
    parameter string OPERATION        = "",
    parameter int    INPUT_COUNT      = 0,
    parameter int    BEAT_COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic                   input_last,
    input  logic [INPUT_COUNT-1:0] bits_in,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic                   bit_out
`ifdef BIT_REDUCER_STREAM_COUNT_EN
    ,
    output logic [BEAT_COUNT_WIDTH-1:0] output_beats
`endif
);

    localparam op_e OP_SEL = op_from_name(OPERATION);

    state_e state_q, state_d;
    logic   partial_q, partial_d;
    logic   result_q, result_d;
    logic   accept;
    logic   chain;

    // A width below one has no meaning for the beat counter; this empty
    // block keeps the parameter referenced in both builds.
    if (BEAT_COUNT_WIDTH < 1) begin : g_invalid_beat_width
    end

    // The partial is only a valid seed while a packet is in progress; in
    // IDLE or DONE an accepted beat opens a fresh packet.
    bit_reducer_step #(
        .INPUT_COUNT (INPUT_COUNT)
    ) u_step (
        .seed       (partial_q),
        .seed_valid (state_q == ST_ACCUM),
        .bits       (bits_in),
        .operation  (OP_SEL),
        .result     (chain)
    );

    // Ready depends on output_ready so a held result can be consumed and a
    // new beat taken in the same cycle, giving one result per cycle.
    always_comb begin
        input_ready  = (state_q != ST_DONE) | output_ready;
        accept       = input_valid & input_ready;
        output_valid = (state_q == ST_DONE);
        bit_out      = result_q;
    end

    // Next-state logic: the handshake on the output side frees DONE first,
    // then an accepted beat decides where the new packet goes.
    always_comb begin
        state_d   = state_q;
        partial_d = partial_q;
        result_d  = result_q;
        case (state_q)
            ST_DONE: begin
                if (output_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            if (input_last) begin
                state_d  = ST_DONE;
                result_d = chain;
            end else begin
                state_d   = ST_ACCUM;
                partial_d = chain;
            end
        end
    end

    // Main state and data registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            partial_q <= 1'b0;
            result_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            partial_q <= partial_d;
            result_q  <= result_d;
        end
    end

`ifdef BIT_REDUCER_STREAM_COUNT_EN
    logic [BEAT_COUNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_COUNT_WIDTH-1:0] out_beats_q, out_beats_d;
    logic [BEAT_COUNT_WIDTH-1:0] cnt_base;
    logic [BEAT_COUNT_WIDTH-1:0] cnt_next;

    // Beats are counted from zero whenever a beat opens a new packet; the
    // count saturates at all ones and is latched with the result.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        out_beats_d = out_beats_q;
        cnt_base    = (state_q == ST_ACCUM) ? beat_cnt_q : '0;
        cnt_next    = (&cnt_base) ? cnt_base
                                  : cnt_base + BEAT_COUNT_WIDTH'(1);
        if (accept) begin
            if (input_last) begin
                out_beats_d = cnt_next;
                beat_cnt_d  = '0;
            end else begin
                beat_cnt_d  = cnt_next;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            beat_cnt_q  <= '0;
            out_beats_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign output_beats = out_beats_q;
`endif

endmodule
